// File: rtl/packet_gatherer.sv
// packet_gatherer: N-channel AXI-Stream packet merger.
// Round-robin arbitration at packet granularity, registered output stage,
// and one 128-bit descriptor pulse per forwarded packet.
module packet_gatherer #(
  parameter int BW    = 32,
  parameter int BWB   = BW / 8,
  parameter int N_CH  = 4,
  parameter int CH_W  = $clog2(N_CH),
  parameter int LEN_W = 16
) (
  input  logic                clk_line,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     stream_in_packet_TVALID,
  input  logic [BW*N_CH-1:0]  stream_in_packet_TDATA,
  input  logic [BWB*N_CH-1:0] stream_in_packet_TKEEP,
  input  logic [N_CH-1:0]     stream_in_packet_TLAST,
  output logic [N_CH-1:0]     stream_in_packet_TREADY,
  output logic                stream_out_packet_TVALID,
  output logic [BW-1:0]       stream_out_packet_TDATA,
  output logic [BWB-1:0]      stream_out_packet_TKEEP,
  output logic                stream_out_packet_TLAST,
  input  logic                stream_out_packet_TREADY,
  output logic                notify_out_metadata_out_VALID,
  output logic [127:0]        notify_out_metadata_out_DATA
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   grant, rr_ptr, pick;
  logic              pick_vld;
  logic              in_ready, accept, accept_last;
  logic              g_valid, g_last;
  logic [BW-1:0]     g_data;
  logic [BWB-1:0]    g_keep;
  logic [LEN_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic [31:0]       byte_cnt, byte_cnt_nxt;
  logic [32:0]       byte_sum;
  logic [15:0]       beat16;
  logic [127:0]      notify_nxt;

  // The output register can take a new beat when empty or draining this cycle.
  assign in_ready    = !stream_out_packet_TVALID || stream_out_packet_TREADY;
  assign accept      = (state == STREAM) && g_valid && in_ready;
  assign accept_last = accept && g_last;

  // Select the granted channel's lane out of the packed input buses.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    g_keep  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == CH_W'(i)) begin
        g_valid = stream_in_packet_TVALID[i];
        g_last  = stream_in_packet_TLAST[i];
        g_data  = stream_in_packet_TDATA[BW*i +: BW];
        g_keep  = stream_in_packet_TKEEP[BWB*i +: BWB];
      end
    end
  end

  // Round-robin search: first requesting channel at or after rr_ptr, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!pick_vld && stream_in_packet_TVALID[(int'(rr_ptr) + k) % N_CH]) begin
        pick_vld = 1'b1;
        pick     = CH_W'((int'(rr_ptr) + k) % N_CH);
      end
    end
  end

  // Saturating counter updates for the beat being accepted this cycle.
  always_comb begin
    beat_cnt_nxt = (beat_cnt == '1) ? beat_cnt : beat_cnt + LEN_W'(1);
    byte_sum     = {1'b0, byte_cnt} + 33'($countones(g_keep));
    byte_cnt_nxt = byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];
    beat16       = 16'(beat_cnt_nxt);
  end

  // Descriptor assembled from the counts including the final beat.
  always_comb begin
    notify_nxt             = '0;
    notify_nxt[CH_W-1:0]   = grant;
    notify_nxt[47:32]      = beat16;
    notify_nxt[95:64]      = byte_cnt_nxt;
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_line or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: arbitrate in IDLE, stay in STREAM until TLAST is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld)    state_nxt = STREAM;
      STREAM:  if (accept_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: only the granted channel sees ready, and only while streaming.
  always_comb begin
    stream_in_packet_TREADY = '0;
    if (state == STREAM) stream_in_packet_TREADY[grant] = in_ready;
  end

  // Grant, round-robin pointer and per-packet counters.
  // NOTE: the datapath registers are reset too, because every output must read 0 in reset.
  always_ff @(posedge clk_line or negedge rst_n) begin
    if (!rst_n) begin
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      byte_cnt <= '0;
    end else if (state == IDLE && pick_vld) begin
      grant    <= pick;
      beat_cnt <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
      if (g_last) rr_ptr <= (grant == CH_W'(N_CH - 1)) ? '0 : grant + CH_W'(1);
    end
  end

  // Output register: load on acceptance, drain on downstream ready, else hold.
  always_ff @(posedge clk_line or negedge rst_n) begin
    if (!rst_n) begin
      stream_out_packet_TVALID <= 1'b0;
      stream_out_packet_TDATA  <= '0;
      stream_out_packet_TKEEP  <= '0;
      stream_out_packet_TLAST  <= 1'b0;
    end else if (accept) begin
      stream_out_packet_TVALID <= 1'b1;
      stream_out_packet_TDATA  <= g_data;
      stream_out_packet_TKEEP  <= g_keep;
      stream_out_packet_TLAST  <= g_last;
    end else if (stream_out_packet_TREADY) begin
      stream_out_packet_TVALID <= 1'b0;
    end
  end

  // One-cycle descriptor pulse following each accepted TLAST beat.
  always_ff @(posedge clk_line or negedge rst_n) begin
    if (!rst_n) begin
      notify_out_metadata_out_VALID <= 1'b0;
      notify_out_metadata_out_DATA  <= '0;
    end else begin
      notify_out_metadata_out_VALID <= accept_last;
      notify_out_metadata_out_DATA  <= accept_last ? notify_nxt : '0;
    end
  end

endmodule

// File: tb/tb_packet_gatherer.sv
// tb_packet_gatherer: directed tests for packet_gatherer (N_CH=4, BW=32).
// A second instance with LEN_W=4 shares all inputs to observe beat-count saturation.
module tb_packet_gatherer;

  logic          clk_line = 1'b0;
  logic          rst_n;
  logic [3:0]    in_valid;
  logic [31:0]   src_data [4];
  logic [3:0]    src_keep [4];
  logic [3:0]    in_last;
  logic [127:0]  in_data;
  logic [15:0]   in_keep;
  logic [3:0]    in_ready, s_in_ready;
  logic          out_valid, out_last, out_tready;
  logic [31:0]   out_data;
  logic [3:0]    out_keep;
  logic          nv;
  logic [127:0]  nd;
  logic          s_out_valid, s_out_last, s_nv;
  logic [31:0]   s_out_data;
  logic [3:0]    s_out_keep;
  logic [127:0]  s_nd;

  typedef struct { logic [31:0] data; logic [3:0] keep; logic last; int cyc; } beat_t;
  typedef struct { logic [127:0] data; int cyc; } ntf_t;

  beat_t        out_q[$];
  ntf_t         ntf_q[$];
  logic [127:0] s_ntf_q[$];

  int vec = 0, err = 0, cyc = 0;
  int ready_err = 0, tr_err = 0, stab_err = 0, nd_err = 0, stall_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [36:0] prev_word;

  assign in_data = {src_data[3], src_data[2], src_data[1], src_data[0]};
  assign in_keep = {src_keep[3], src_keep[2], src_keep[1], src_keep[0]};

  packet_gatherer u_dut (
    .clk_line(clk_line), .rst_n(rst_n),
    .stream_in_packet_TVALID(in_valid), .stream_in_packet_TDATA(in_data),
    .stream_in_packet_TKEEP(in_keep), .stream_in_packet_TLAST(in_last),
    .stream_in_packet_TREADY(in_ready),
    .stream_out_packet_TVALID(out_valid), .stream_out_packet_TDATA(out_data),
    .stream_out_packet_TKEEP(out_keep), .stream_out_packet_TLAST(out_last),
    .stream_out_packet_TREADY(out_tready),
    .notify_out_metadata_out_VALID(nv), .notify_out_metadata_out_DATA(nd)
  );

  packet_gatherer #(.LEN_W(4)) u_sat (
    .clk_line(clk_line), .rst_n(rst_n),
    .stream_in_packet_TVALID(in_valid), .stream_in_packet_TDATA(in_data),
    .stream_in_packet_TKEEP(in_keep), .stream_in_packet_TLAST(in_last),
    .stream_in_packet_TREADY(s_in_ready),
    .stream_out_packet_TVALID(s_out_valid), .stream_out_packet_TDATA(s_out_data),
    .stream_out_packet_TKEEP(s_out_keep), .stream_out_packet_TLAST(s_out_last),
    .stream_out_packet_TREADY(out_tready),
    .notify_out_metadata_out_VALID(s_nv), .notify_out_metadata_out_DATA(s_nd)
  );

  always #5 clk_line = ~clk_line;

  always @(posedge clk_line) cyc++;

  // Monitor: samples 1 time unit before each rising edge.
  always @(negedge clk_line) begin
    #4;
    if (rst_n) begin
      if ($countones(in_ready) > 1) ready_err++;
      if (out_valid && !out_tready && in_ready != 4'b0) tr_err++;
      if (prev_stall && out_valid && ({out_data, out_keep, out_last} !== prev_word)) stab_err++;
      if (!nv && nd != 128'd0) nd_err++;
      prev_stall = out_valid && !out_tready;
      prev_word  = {out_data, out_keep, out_last};
      if (out_valid && !out_tready) stall_cnt++;
      if (out_valid && out_tready) begin
        beat_t b;
        b.data = out_data; b.keep = out_keep; b.last = out_last; b.cyc = cyc;
        out_q.push_back(b);
      end
      if (nv) begin
        ntf_t n;
        n.data = nd; n.cyc = cyc;
        ntf_q.push_back(n);
      end
      if (s_nv) s_ntf_q.push_back(s_nd);
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [127:0] ntf(input int ch, input int beats, input int bytes);
    return 128'(ch) | (128'(beats) << 32) | (128'(bytes) << 64);
  endfunction

  function automatic logic [31:0] word(input int ch, input int pkt, input int b);
    return {8'(ch), 8'(pkt), 16'(b)};
  endfunction

  task automatic clear_queues();
    out_q.delete();
    ntf_q.delete();
    s_ntf_q.delete();
  endtask

  task automatic drain();
    repeat (5) @(negedge clk_line);
  endtask

  // Called at a falling edge; returns at the falling edge after the beat is taken.
  task automatic wait_accept(input int ch);
    bit done = 1'b0;
    int n = 0;
    while (!done) begin
      #1;
      if (in_ready[ch] === 1'b1) done = 1'b1;
      @(negedge clk_line);
      n++;
      if (!done && n > 200) begin
        vec++; err++;
        $display("FAIL accept_timeout ch%0d: no TREADY after %0d cycles", ch, n);
        done = 1'b1;
      end
    end
  endtask

  task automatic send_pkt(input int ch, input int pkt, input int n,
                          input logic [3:0] klast, input int gap_at);
    for (int b = 0; b < n; b++) begin
      if (gap_at > 0 && b == gap_at) begin
        in_valid[ch] = 1'b0;
        repeat (3) @(negedge clk_line);
      end
      src_data[ch] = word(ch, pkt, b);
      src_keep[ch] = (b == n - 1) ? klast : 4'hF;
      in_last[ch]  = (b == n - 1);
      in_valid[ch] = 1'b1;
      wait_accept(ch);
    end
    in_valid[ch] = 1'b0;
    in_last[ch]  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vec++; if ({out_valid, out_last, nv} !== 3'b000) begin err++;
      $display("FAIL reset_flags: got %b required 000", {out_valid, out_last, nv}); end
    vec++; if (out_data !== 32'd0) begin err++;
      $display("FAIL reset_tdata: got %h required 0", out_data); end
    vec++; if (out_keep !== 4'd0) begin err++;
      $display("FAIL reset_tkeep: got %h required 0", out_keep); end
    vec++; if (in_ready !== 4'd0) begin err++;
      $display("FAIL reset_tready: got %b required 0000", in_ready); end
    vec++; if (nd !== 128'd0) begin err++;
      $display("FAIL reset_notify_data: got %h required 0", nd); end
    vec++; if (s_out_valid !== 1'b0) begin err++;
      $display("FAIL reset_sat_valid: got %b required 0", s_out_valid); end
    @(negedge clk_line);
    rst_n = 1'b1;
    @(negedge clk_line);
  endtask

  task automatic test_single_source();
    int c0;
    clear_queues();
    c0 = cyc;
    src_data[0] = 32'hA000_0001; src_keep[0] = 4'hF; in_last[0] = 1'b0; in_valid[0] = 1'b1;
    wait_accept(0);
    src_data[0] = 32'hA000_0002; src_keep[0] = 4'hF;
    wait_accept(0);
    src_data[0] = 32'hA000_0003; src_keep[0] = 4'h3; in_last[0] = 1'b1;
    wait_accept(0);
    in_valid[0] = 1'b0; in_last[0] = 1'b0;
    drain();
    vec++; if (out_q.size() !== 3) begin err++;
      $display("FAIL single_nbeats: got %0d required 3", out_q.size()); end
    if (out_q.size() == 3) begin
      vec++; if (out_q[0].data !== 32'hA000_0001 || out_q[2].data !== 32'hA000_0003) begin err++;
        $display("FAIL single_data: got %h/%h required A0000001/A0000003", out_q[0].data, out_q[2].data); end
      vec++; if ({out_q[1].keep, out_q[2].keep} !== 8'hF3 || out_q[2].last !== 1'b1 || out_q[1].last !== 1'b0) begin err++;
        $display("FAIL single_keep_last: got %h%h last %b%b required F3 last 01",
                 out_q[1].keep, out_q[2].keep, out_q[1].last, out_q[2].last); end
      vec++; if (out_q[0].cyc - c0 !== 2 || out_q[2].cyc - c0 !== 4) begin err++;
        $display("FAIL single_latency: got t+%0d..t+%0d required t+2..t+4",
                 out_q[0].cyc - c0, out_q[2].cyc - c0); end
    end
    vec++; if (ntf_q.size() !== 1) begin err++;
      $display("FAIL single_notify_count: got %0d required 1", ntf_q.size()); end
    if (ntf_q.size() == 1) begin
      vec++; if (ntf_q[0].data !== ntf(0, 3, 10)) begin err++;
        $display("FAIL single_notify_data: got %h required %h", ntf_q[0].data, ntf(0, 3, 10)); end
      vec++; if (ntf_q[0].cyc - c0 !== 4) begin err++;
        $display("FAIL single_notify_timing: got t+%0d required t+4", ntf_q[0].cyc - c0); end
    end
  endtask

  task automatic test_fairness();
    @(negedge clk_line);
    rst_n = 1'b0;
    @(negedge clk_line);
    clear_queues();
    rst_n = 1'b1;
    fork
      begin send_pkt(0, 0, 2, 4'hF, 0); send_pkt(0, 1, 2, 4'hF, 0); end
      begin send_pkt(1, 0, 2, 4'hF, 0); send_pkt(1, 1, 2, 4'hF, 0); end
      begin send_pkt(2, 0, 2, 4'hF, 0); send_pkt(2, 1, 2, 4'hF, 0); end
      begin send_pkt(3, 0, 2, 4'hF, 0); send_pkt(3, 1, 2, 4'hF, 0); end
    join
    drain();
    vec++; if (out_q.size() !== 16) begin err++;
      $display("FAIL fair_nbeats: got %0d required 16", out_q.size()); end
    if (out_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        vec++; if (out_q[i].data !== word((i / 2) % 4, i / 8, i % 2)) begin err++;
          $display("FAIL fair_order beat%0d: got %h required %h", i, out_q[i].data, word((i / 2) % 4, i / 8, i % 2)); end
      end
      vec++; if (out_q[2].cyc - out_q[1].cyc !== 2) begin err++;
        $display("FAIL fair_gap: got %0d cycles required 2", out_q[2].cyc - out_q[1].cyc); end
    end
    vec++; if (ntf_q.size() !== 8) begin err++;
      $display("FAIL fair_notify_count: got %0d required 8", ntf_q.size()); end
    if (ntf_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        vec++; if (ntf_q[i].data !== ntf(i % 4, 2, 8)) begin err++;
          $display("FAIL fair_notify%0d: got %h required %h", i, ntf_q[i].data, ntf(i % 4, 2, 8)); end
      end
    end
  endtask

  task automatic test_back_pressure();
    int pat [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
    clear_queues();
    stall_cnt = 0;
    fork
      send_pkt(2, 3, 4, 4'hF, 0);
      begin
        for (int i = 0; i < 9; i++) begin
          out_tready = pat[i][0];
          @(negedge clk_line);
        end
        out_tready = 1'b1;
      end
    join
    drain();
    vec++; if (stall_cnt !== 2) begin err++;
      $display("FAIL bp_stall_cycles: got %0d required 2", stall_cnt); end
    vec++; if (out_q.size() !== 4) begin err++;
      $display("FAIL bp_nbeats: got %0d required 4", out_q.size()); end
    if (out_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        vec++; if (out_q[i].data !== word(2, 3, i)) begin err++;
          $display("FAIL bp_beat%0d: got %h required %h", i, out_q[i].data, word(2, 3, i)); end
      end
    end
    vec++; if (ntf_q.size() !== 1 || ntf_q[0].data !== ntf(2, 4, 16)) begin err++;
      $display("FAIL bp_notify: got %0d entries first %h required 1 entry %h",
               ntf_q.size(), (ntf_q.size() > 0) ? ntf_q[0].data : 128'd0, ntf(2, 4, 16)); end
    vec++; if (stab_err !== 0 || tr_err !== 0) begin err++;
      $display("FAIL bp_stall_rules: got %0d unstable, %0d ready-while-stalled required 0,0", stab_err, tr_err); end
  endtask

  task automatic test_gaps_and_single_beat();
    clear_queues();
    fork
      send_pkt(1, 0, 4, 4'h1, 2);
      begin repeat (3) @(negedge clk_line); send_pkt(3, 0, 1, 4'h6, 0); end
    join
    drain();
    vec++; if (out_q.size() !== 5) begin err++;
      $display("FAIL gap_nbeats: got %0d required 5", out_q.size()); end
    if (out_q.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        vec++; if (out_q[i].data !== word(1, 0, i)) begin err++;
          $display("FAIL gap_ch1_beat%0d: got %h required %h", i, out_q[i].data, word(1, 0, i)); end
      end
      vec++; if (out_q[4].data !== word(3, 0, 0) || out_q[4].keep !== 4'h6 || out_q[4].last !== 1'b1) begin err++;
        $display("FAIL gap_ch3_beat: got %h keep %h last %b required %h keep 6 last 1",
                 out_q[4].data, out_q[4].keep, out_q[4].last, word(3, 0, 0)); end
    end
    vec++; if (ntf_q.size() !== 2) begin err++;
      $display("FAIL gap_notify_count: got %0d required 2", ntf_q.size()); end
    if (ntf_q.size() == 2) begin
      vec++; if (ntf_q[0].data !== ntf(1, 4, 13)) begin err++;
        $display("FAIL gap_notify_ch1: got %h required %h", ntf_q[0].data, ntf(1, 4, 13)); end
      vec++; if (ntf_q[1].data !== ntf(3, 1, 2)) begin err++;
        $display("FAIL gap_notify_ch3: got %h required %h", ntf_q[1].data, ntf(3, 1, 2)); end
    end
  endtask

  task automatic test_reset_mid_packet();
    // Leave rr_ptr at 2 so a restart from 0 is observable afterwards.
    send_pkt(1, 5, 1, 4'hF, 0);
    drain();
    clear_queues();
    src_keep[0] = 4'hF; in_last[0] = 1'b0;
    src_data[0] = word(0, 7, 0); in_valid[0] = 1'b1;
    wait_accept(0);
    src_data[0] = word(0, 7, 1);
    wait_accept(0);
    src_data[0] = word(0, 7, 2);
    #1;
    vec++; if (out_valid !== 1'b1) begin err++;
      $display("FAIL rstmid_pre_valid: got %b required 1", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    vec++; if ({out_valid, out_last, nv, in_ready} !== 7'd0 || out_data !== 32'd0 || out_keep !== 4'd0) begin err++;
      $display("FAIL rstmid_outputs: got v%b l%b n%b r%b d%h k%h required all 0",
               out_valid, out_last, nv, in_ready, out_data, out_keep); end
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk_line);
    vec++; if (ntf_q.size() !== 0) begin err++;
      $display("FAIL rstmid_no_notify: got %0d required 0", ntf_q.size()); end
    clear_queues();
    rst_n = 1'b1;
    fork
      send_pkt(0, 8, 2, 4'hF, 0);
      send_pkt(3, 8, 1, 4'hF, 0);
    join
    drain();
    vec++; if (out_q.size() !== 3) begin err++;
      $display("FAIL rstmid_nbeats: got %0d required 3", out_q.size()); end
    if (out_q.size() == 3) begin
      vec++; if (out_q[0].data !== word(0, 8, 0) || out_q[1].data !== word(0, 8, 1) || out_q[2].data !== word(3, 8, 0)) begin err++;
        $display("FAIL rstmid_order: got %h %h %h required %h %h %h", out_q[0].data, out_q[1].data,
                 out_q[2].data, word(0, 8, 0), word(0, 8, 1), word(3, 8, 0)); end
    end
    vec++; if (ntf_q.size() !== 2 || ntf_q[0].data !== ntf(0, 2, 8)) begin err++;
      $display("FAIL rstmid_notify: got %0d entries first %h required 2 entries first %h",
               ntf_q.size(), (ntf_q.size() > 0) ? ntf_q[0].data : 128'd0, ntf(0, 2, 8)); end
  endtask

  task automatic test_saturation();
    clear_queues();
    send_pkt(0, 9, 20, 4'hF, 0);
    drain();
    vec++; if (ntf_q.size() !== 1 || ntf_q[0].data !== ntf(0, 20, 80)) begin err++;
      $display("FAIL sat_wide_notify: got %0d entries first %h required %h",
               ntf_q.size(), (ntf_q.size() > 0) ? ntf_q[0].data : 128'd0, ntf(0, 20, 80)); end
    vec++; if (s_ntf_q.size() !== 1 || s_ntf_q[0] !== ntf(0, 15, 80)) begin err++;
      $display("FAIL sat_len4_notify: got %0d entries first %h required %h",
               s_ntf_q.size(), (s_ntf_q.size() > 0) ? s_ntf_q[0] : 128'd0, ntf(0, 15, 80)); end
  endtask

  task automatic test_hygiene();
    vec++; if (ready_err !== 0) begin err++;
      $display("FAIL multi_tready: got %0d cycles with >1 TREADY required 0", ready_err); end
    vec++; if (nd_err !== 0) begin err++;
      $display("FAIL notify_data_idle: got %0d cycles nonzero DATA with VALID low required 0", nd_err); end
  endtask

  initial begin
    in_valid   = '0;
    in_last    = '0;
    out_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_data[i] = '0;
      src_keep[i] = '0;
    end
    test_reset();
    test_single_source();
    test_fairness();
    test_back_pressure();
    test_gaps_and_single_beat();
    test_reset_mid_packet();
    test_saturation();
    test_hygiene();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
